// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types, defaults and select-width helper for demux_rr_sched
package demux_pkg;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  localparam int NCH_DEF = 4;
  localparam int DW_DEF  = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/demux_ch_cnt.sv
// rtl/demux_ch_cnt.sv - per-channel 16-bit delivered-item counter bank
// Only compiled when DEMUX_CNT_EN is defined; cnt_clr wins over a coincident increment.
`ifdef DEMUX_CNT_EN
module demux_ch_cnt #(
  parameter int NCH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cnt_clr,
  input  logic [NCH-1:0]    inc,
  output logic [NCH*16-1:0] ch_cnt
);

  logic [NCH-1:0][15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (inc[k]) cnt[k] <= cnt[k] + 16'd1;
      end
    end
  end

  assign ch_cnt = cnt;

endmodule
`endif

// File: rtl/demux_rr_sched.sv
// rtl/demux_rr_sched.sv - one-item-deep 1-to-NCH demux with round-robin or explicit steering
// DEMUX_CNT_EN adds per-channel delivery counters (ch_cnt, cnt_clr).
module demux_rr_sched
  import demux_pkg::*;
#(
  parameter  int DW   = DW_DEF,
  parameter  int NCH  = NCH_DEF,
  localparam int SELW = clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [SELW-1:0]   in_sel,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [DW-1:0]     out_data,
  output logic              busy
`ifdef DEMUX_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [NCH*16-1:0] ch_cnt
`endif
);

  state_t          state, state_nxt;
  logic            hold_vld, deliver, accept;
  logic [SELW-1:0] hold_sel, rr_ptr;

  assign hold_vld = (state == S_HOLD);
  assign deliver  = hold_vld & out_ready[hold_sel];
  // rst_n gating keeps the producer from seeing ready while the block is held in reset
  assign in_ready = rst_n & en & (~hold_vld | deliver);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_HOLD;
      S_HOLD:  if (deliver && !accept) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = '0;
    busy      = 1'b0;
    if (state == S_HOLD) begin
      out_valid[hold_sel] = 1'b1;
      busy                = 1'b1;
    end
  end

  // Destination is frozen at accept, so later mode/in_sel changes only affect the next item
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_sel <= '0;
      out_data <= '0;
      rr_ptr   <= '0;
    end else if (accept) begin
      hold_sel <= mode ? in_sel : rr_ptr;
      out_data <= in_data;
      if (!mode) rr_ptr <= rr_ptr + SELW'(1);
    end
  end

`ifdef DEMUX_CNT_EN
  demux_ch_cnt #(.NCH(NCH)) u_ch_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .cnt_clr (cnt_clr),
    .inc     (out_valid & out_ready),
    .ch_cnt  (ch_cnt)
  );
`endif

endmodule

// File: tb/tb_demux_rr_sched.sv
// tb/tb_demux_rr_sched.sv - scoreboard bench for demux_rr_sched (DEMUX_CNT_EN optional)
`timescale 1ns/1ps
module tb_demux_rr_sched;
  localparam int DW = 8, NCH = 4, SELW = 2;

  logic clk = 0, rst_n = 0, en = 0, mode = 0, in_valid = 0;
  logic in_ready, busy;
  logic [DW-1:0] in_data = '0, out_data;
  logic [SELW-1:0] in_sel = '0;
  logic [NCH-1:0] out_valid, out_ready = '0;
`ifdef DEMUX_CNT_EN
  logic cnt_clr = 0;
  logic [NCH*16-1:0] ch_cnt;
  int unsigned cnt_m[NCH];
`endif

  always #5 clk = ~clk;

  demux_rr_sched #(.DW(DW), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
`ifdef DEMUX_CNT_EN
    , .cnt_clr(cnt_clr), .ch_cnt(ch_cnt)
`endif
  );

  typedef struct {int ch; logic [DW-1:0] d;} item_t;
  item_t q[$];
  int rr_m = 0, checks = 0, errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: an accepted item goes to in_sel (explicit) or to the next round-robin slot
  always @(negedge clk) begin
    #1;
    if (rst_n && in_valid && in_ready) begin
      item_t it;
      it.ch = mode ? int'(in_sel) : rr_m;
      it.d  = in_data;
      if (!mode) rr_m = (rr_m + 1) % NCH;
      q.push_back(it);
    end
  end

  // Monitor: the head of the queue is the one item the DUT should be presenting
  always @(negedge clk) begin
    if (rst_n) begin
      logic [NCH-1:0] exp_ov;
      int dch;
      exp_ov = '0;
      dch = -1;
      if (q.size() != 0) exp_ov[q[0].ch] = 1'b1;
      check("out_valid", out_valid, exp_ov);
      check("busy", busy, q.size() != 0);
      check("in_ready", in_ready, en && (q.size() == 0 || out_ready[q[0].ch]));
      if (q.size() != 0) begin
        check("out_data", out_data, q[0].d);
        if (out_ready[q[0].ch]) begin
          dch = q[0].ch;
          void'(q.pop_front());
        end
      end
`ifdef DEMUX_CNT_EN
      for (int k = 0; k < NCH; k++) check("ch_cnt", ch_cnt[16*k +: 16], cnt_m[k] & 16'hFFFF);
      if (cnt_clr) begin
        for (int k = 0; k < NCH; k++) cnt_m[k] = 0;
      end else if (dch >= 0) begin
        cnt_m[dch] = (cnt_m[dch] + 1) & 16'hFFFF;
      end
`endif
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic m, input logic [SELW-1:0] s);
    int n;
    n = 0;
    in_valid = 1; in_data = d; mode = m; in_sel = s;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    check("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 0;
    #1;
    check("rst_out_valid", out_valid, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_data", out_data, '0);
    q.delete();
    rr_m = 0;
`ifdef DEMUX_CNT_EN
    for (int k = 0; k < NCH; k++) cnt_m[k] = 0;
`endif
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] rr_data[5];
    bit done;
    int n;
    rr_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    en = 1;
    repeat (2) @(posedge clk);
    #1;
    check("init_out_valid", out_valid, '0);
    check("init_busy", busy, 1'b0);
    check("init_in_ready", in_ready, 1'b0);
    rst_n = 1;

    out_ready = '1;
    foreach (rr_data[i]) send(rr_data[i], 1'b0, '0);
    idle(2);

    out_ready = '0;
    send(8'h77, 1'b0, '0);
    idle(1);
    do_reset();

    out_ready = 4'b1101;
    send(8'hA0, 1'b0, '0);
    send(8'hA1, 1'b0, '0);
    fork
      send(8'hA2, 1'b0, '0);
      begin idle(4); out_ready = '1; end
    join
    idle(2);
    send(8'h5A, 1'b0, '0);

    send(8'h01, 1'b1, 2'd3);
    send(8'h02, 1'b1, 2'd3);
    send(8'h03, 1'b1, 2'd2);
    send(8'h04, 1'b0, 2'd1);
    idle(2);

    out_ready = '0;
    send(8'h66, 1'b0, '0);
    en = 0;
    idle(3);
    out_ready = '1;
    idle(3);
    en = 1;

`ifdef DEMUX_CNT_EN
    cnt_clr = 1; idle(1); cnt_clr = 0;
    repeat (3) send(8'hC0, 1'b1, 2'd2);
    idle(2);
    check("cnt_ch2_three", ch_cnt[47:32], 16'd3);
    out_ready = '0;
    send(8'hC3, 1'b1, 2'd2);
    idle(1);
    cnt_clr = 1; out_ready = '1;
    idle(1);
    cnt_clr = 0;
    idle(1);
    check("cnt_ch2_clr", ch_cnt[47:32], 16'd0);
`endif

    done = 0;
    fork
      begin
        repeat (150) begin
          if ($urandom_range(0, 5) == 0) begin
            en = 0;
            idle($urandom_range(1, 3));
            en = 1;
          end
          send(DW'($urandom), 1'($urandom_range(0, 1)), SELW'($urandom_range(0, NCH - 1)));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = NCH'($urandom);
        end
      end
    join
    out_ready = '1;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", q.size(), 0);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
